serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor; the inverse operation of the team's 4-bit ripple adder.
- Computes D = A - B, one bit per clock, LSB first, with a start/busy/done handshake.
- Sits beside the adder in the arithmetic examples as a small sequential datapath block with a shared-bus style request interface.

Parameters:
- WIDTH, 4, operand and difference width in bits (legal values 2 to 32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when the block is not busy.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while the subtraction is in progress.
- done  output  1  single-cycle pulse; result is valid.
- D  output  WIDTH  difference, (A - B) mod 2^WIDTH.
- Bout  output  1  borrow out; 1 iff A < B (unsigned).

Behaviour:
- Reset: asynchronous, active-low. On rst_n low: state=IDLE, busy=0, done=0, D=0, Bout=0, internal count/borrow/shift registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k latches A and B into shift registers.
  - Sets borrow=0, count=0; next state RUN, busy=1 from edge k.
- RUN (WIDTH edges):
  - Per edge, with a/b = current LSBs: d = a^b^bor; bor_next = (~a&b) | (~(a^b)&bor).
  - Operand registers shift right.
  - d shifts into the MSB of the result register.
  - count increments.
- Final RUN edge (count=WIDTH-1), i.e. edge k+WIDTH:
  - D <= completed result; Bout <= final borrow.
  - busy <= 0, done <= 1; next state DONE.
- DONE:
  - Lasts one cycle; done=1.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation) and done drops.
  - Otherwise return to IDLE; done drops.
- Latency: WIDTH cycles from the accepting edge to done. Throughput: one result per WIDTH+1 cycles.
- D and Bout hold their value until the next completion or reset. They are not disturbed during a subsequent RUN; only internal registers change.
- start while busy=1: ignored, no effect on the operation in flight.
- A/B changes after the accepting edge: no effect.
- {Bout,D} equals A - B as a WIDTH+1-bit two's-complement value.
- Reset mid-RUN: operation aborted, all outputs return to reset values; no done pulse.
- No X propagation: all state registers are reset.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit, reset 0), registered with D at completion.
  - ovf = signed two's-complement overflow = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]).
  - Equivalently, borrow into MSB XOR borrow out of MSB.
  - Held like D.
- Undefined: port ovf absent, no related logic; all other behaviour identical.

Test Plan:
- Reset, then A=3, B=4, start pulse -> busy for 4 cycles, done pulse at edge k+4, D=15, Bout=1.
- A=9, B=2 -> D=7, Bout=0; then A=0, B=5 issued in the DONE cycle -> accepted back-to-back, D=11, Bout=1 four cycles later.
- A=15, B=15 -> D=0, Bout=0; A=10, B=10 -> D=0, Bout=0; done exactly one cycle wide each time.
- During RUN of A=12, B=3, pulse start with A=1, B=1 -> ignored; result D=9, Bout=0; no extra done.
- Assert rst_n=0 at cycle 2 of RUN -> busy=0, done=0, D=0, Bout=0 immediately; no done pulse afterwards.
- With SERIAL_SUB_OVF_EN: A=8 (-8), B=1 -> D=7, Bout=0, ovf=1; A=5, B=3 -> D=2, ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B, one bit per clock, LSB first, start/busy/done handshake.
// Optional signed-overflow output ovf is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             bit_a, bit_b, diff_bit, bor_nxt;
  logic [WIDTH-1:0] res_shifted;

  assign bit_a       = a_q[0];
  assign bit_b       = b_q[0];
  assign diff_bit    = bit_a ^ bit_b ^ bor_q;
  assign bor_nxt     = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bor_q);
  assign res_shifted = {diff_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    bor_d   = bor_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new request exactly like IDLE for back-to-back use.
        if (start) begin
          a_d     = A;
          b_d     = B;
          res_d   = '0;
          cnt_d   = '0;
          bor_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shifted;
        bor_d = bor_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          dout_d  = res_shifted;
          bout_d  = bor_nxt;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
`ifdef SERIAL_SUB_OVF_EN
          // Borrow into the MSB differs from borrow out of it on signed overflow.
          ovf_d   = bor_q ^ bor_nxt;
`endif
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = dout_q;
  assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
